// File: rtl/pipe_ctrl_if.sv
// ID/EX-side handshake bundle between the pipeline datapath and pipe_ctrl.
// Master is the datapath, slave is the controller.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid_inst;
  logic [4:0]       id_rs1_idx;
  logic [4:0]       id_rs2_idx;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_reg_wr;
  logic [4:0]       id_dest_reg_idx;
  logic             id_rd_mem;
  logic             id_halt;
  logic             ex_take_branch;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid_inst, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           id_reg_wr, id_dest_reg_idx, id_rd_mem, id_halt, ex_take_branch,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid_inst, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           id_reg_wr, id_dest_reg_idx, id_rd_mem, id_halt, ex_take_branch,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Scoreboard pipeline controller: RAW stalls, branch flush, ebreak drain-then-halt.
// Define PIPE_CTRL_FWD_EN when EX/MEM and MEM/WB forwarding paths exist.
module pipe_ctrl #(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  // Scoreboard entries are 2 bits wide, so WB_LAT is expected to be <= 3.
  localparam logic [1:0] WbLat = 2'(WB_LAT);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e               state_q, state_d;
  logic [31:0][1:0]     pend_q, pend_d;
  logic [1:0]           drain_q, drain_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic [CNT_W-1:0]     flush_q, flush_d;

  logic                 run;
  logic                 hz_rs1, hz_rs2;
  logic                 hazard;
  logic                 issue;
  logic                 mark;
  logic [1:0]           iss_lat;

  logic                 pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;

  assign run    = (state_q == StRun);
  assign hz_rs1 = bus.id_uses_rs1 && (bus.id_rs1_idx != 5'd0) &&
                  (pend_q[bus.id_rs1_idx] != 2'd0);
  assign hz_rs2 = bus.id_uses_rs2 && (bus.id_rs2_idx != 5'd0) &&
                  (pend_q[bus.id_rs2_idx] != 2'd0);
  assign hazard = bus.id_valid_inst && (hz_rs1 || hz_rs2);
  assign issue  = bus.id_valid_inst && !hazard && !bus.ex_take_branch && run;
  assign mark   = issue && bus.id_reg_wr && (bus.id_dest_reg_idx != 5'd0);

`ifdef PIPE_CTRL_FWD_EN
  // Only a load result is late enough to need one bubble when forwarding exists.
  assign iss_lat = bus.id_rd_mem ? 2'd1 : 2'd0;
`else
  assign iss_lat = WbLat;
  logic unused_rd_mem;
  assign unused_rd_mem = bus.id_rd_mem;
`endif

  // Next-state: scoreboard, FSM, drain counter, perf counters.
  always_comb begin
    pend_d  = '0;
    state_d = state_q;
    drain_d = drain_q;
    stall_d = stall_q;
    flush_d = flush_q;

    for (int i = 1; i < 32; i++) begin
      pend_d[i] = (pend_q[i] != 2'd0) ? pend_q[i] - 2'd1 : 2'd0;
    end
    if (mark) begin
      pend_d[bus.id_dest_reg_idx] = iss_lat;
    end

    if (run && bus.ex_take_branch) begin
      flush_d = flush_q + CNT_W'(1);
    end else if (run && hazard) begin
      stall_d = stall_q + CNT_W'(1);
    end

    unique case (state_q)
      StRun: begin
        if (issue && bus.id_halt) begin
          state_d = StDrain;
          drain_d = WbLat;
        end
      end
      StDrain: begin
        if (drain_q != 2'd0) begin
          drain_d = drain_q - 2'd1;
        end
        if (drain_q <= 2'd1) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pend_q  <= '0;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Control outputs; the defaults are the frozen/noop pattern used in reset, DRAIN and HALT.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    halted       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (bus.ex_take_branch) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
          end else begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
          end
        end
        StDrain: begin
          halted = 1'b0;
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.halted       = halted;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expected control patterns are queued
// as stimulus is driven and popped when the outputs are sampled.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 32;
`ifdef PIPE_CTRL_FWD_EN
  localparam int unsigned AluStalls  = 0;
  localparam int unsigned LoadStalls = 1;
`else
  localparam int unsigned AluStalls  = 3;
  localparam int unsigned LoadStalls = 3;
`endif

  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, halted}
  localparam logic [4:0] CtlRun   = 5'b11000;
  localparam logic [4:0] CtlStall = 5'b00010;
  localparam logic [4:0] CtlFlush = 5'b11110;
  localparam logic [4:0] CtlDrain = 5'b00110;
  localparam logic [4:0] CtlHalt  = 5'b00111;
  localparam logic [4:0] CtlRst   = 5'b00110;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_ctrl #(.WB_LAT(3), .CNT_W(CntW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic wr,
                       input logic [4:0] rd, input logic ld, input logic hlt,
                       input logic br);
    bus.id_valid_inst   = v;
    bus.id_rs1_idx      = rs1;
    bus.id_uses_rs1     = u1;
    bus.id_rs2_idx      = rs2;
    bus.id_uses_rs2     = u2;
    bus.id_reg_wr       = wr;
    bus.id_dest_reg_idx = rd;
    bus.id_rd_mem       = ld;
    bus.id_halt         = hlt;
    bus.ex_take_branch  = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_ctl(input string tag, input logic [4:0] ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    exp_q.push_back(e);
  endtask

  // Sample mid-cycle, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, {59'd0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_bubble,
                  bus.halted}, {59'd0, e.ctl});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) begin
      expect_ctl("idle", CtlRun);
      tick();
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_stall));
    chk({tag, "_flush_cnt"}, 64'(bus.flush_cnt), 64'(exp_flush));
  endtask

  // Producer writes prd, consumer reads prd (and crs2) and writes crd.
  task automatic raw_pair(input string tag, input logic [4:0] prd, input logic ld,
                          input logic [4:0] crs2, input logic [4:0] crd, input int stalls);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, prd, ld, 1'b0, 1'b0);
    expect_ctl({tag, "_prod"}, CtlRun);
    tick();
    drive(1'b1, prd, 1'b1, crs2, 1'b1, 1'b1, crd, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < stalls; i++) begin
      expect_ctl({tag, "_stall"}, CtlStall);
      tick();
      exp_stall++;
    end
    expect_ctl({tag, "_issue"}, CtlRun);
    tick();
    idle_cycles(4);
    chk_cnts(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_at;
    idle();
    @(posedge clk);
    #1;

    // Reset pattern, with a valid instruction present to show it is ignored.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    expect_ctl("rst_out", CtlRst);
    tick();
    expect_ctl("rst_out2", CtlRst);
    tick();
    chk_cnts("rst");
    rst = 1'b0;

    // add x5 ; sub x6,x5,x1
    raw_pair("alu_raw", 5'd5, 1'b0, 5'd1, 5'd6, AluStalls);

    // Writes to x0 never create a hazard.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_ctl("x0_prod", CtlRun);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    expect_ctl("x0_cons", CtlRun);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_ctl("x0_cons2", CtlRun);
    tick();
    idle_cycles(4);

    // Branch during a stall: load x11, consumer writes x12, branch squashes it.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    expect_ctl("br_prod", CtlRun);
    tick();
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    expect_ctl("br_stall", CtlStall);
    tick();
    exp_stall++;
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    expect_ctl("br_flush", CtlFlush);
    tick();
    exp_flush++;
    chk_cnts("br");
    drive(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
    expect_ctl("br_squashed_rd", CtlRun);
    tick();
    idle_cycles(4);

    // lw x7 ; add x8,x7,x7   then   add x9 ; or x10,x9,x0
    raw_pair("load_use", 5'd7, 1'b1, 5'd7, 5'd8, LoadStalls);
    raw_pair("alu_fwd", 5'd9, 1'b0, 5'd0, 5'd10, AluStalls);

    // ebreak: drain three cycles, then hold halted despite branch pulses.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_ctl("ebreak", CtlRun);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 1'(i == 1));
      expect_ctl("drain", CtlDrain);
      tick();
    end
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd21, 1'b0, 1'b0, 1'(i % 2));
      expect_ctl("halt", CtlHalt);
      tick();
    end
    chk_cnts("halt");

    // Reset out of HALT, then reset again in the middle of a stall.
    rst = 1'b1;
    idle();
    expect_ctl("rst_halt", CtlRst);
    tick();
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    chk_cnts("rst_halt");
    rst_at = (LoadStalls >= 2) ? 2 : 1;
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    expect_ctl("rs_prod", CtlRun);
    tick();
    drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < rst_at; i++) begin
      expect_ctl("rs_stall", CtlStall);
      tick();
    end
    rst = 1'b1;
    expect_ctl("rs_rst", CtlRst);
    tick();
    rst = 1'b0;
    expect_ctl("rs_issue", CtlRun);
    tick();
    chk_cnts("rs");
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
